// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read channel between SLOTS ROM requesters.
// Optional watchdog enabled by defining JTFRAME_SDRAM_ARB_TIMEOUT_EN.
module jtframe_sdram_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                loop_rst,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*32-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read,
    output logic                refresh_en,
    output logic                timeout_err
);

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d, grant_q, grant_d, gsel, grant_nxt, idx;
    logic                found, req_d, ref_d, done, hit, expired, tmo_set, tmo_q;
    logic [AW-1:0]       addr_d, gaddr;
    logic [SLOTS*AW-1:0] addr_q;
    logic [SLOTS-1:0]    pending, ok_d;

    assign pending   = slot_req & ~slot_ok;
    assign grant_nxt = (grant_q == PW'(SLOTS - 1)) ? '0 : grant_q + PW'(1);
    assign gaddr     = slot_addr[grant_q*AW +: AW];
    assign hit       = done && slot_req[grant_q] && (gaddr == sdram_addr);

    // Walk downward so the pending slot closest to ptr is the last (winning) assignment
    always_comb begin
        found = 1'b0;
        gsel  = ptr_q;
        idx   = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % SLOTS);
            if (pending[idx]) begin
                found = 1'b1;
                gsel  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        req_d   = sdram_req;
        addr_d  = sdram_addr;
        ref_d   = refresh_en;
        done    = 1'b0;
        tmo_set = 1'b0;
        if (loop_rst) begin
            state_d = StIdle;
            req_d   = 1'b0;
            ref_d   = 1'b1;
            ptr_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        grant_d = gsel;
                        addr_d  = slot_addr[gsel*AW +: AW];
                        req_d   = 1'b1;
                        ref_d   = 1'b0;
                        state_d = StReq;
                    end else begin
                        ref_d = 1'b1;
                    end
                end
                StReq: begin
                    if (sdram_ack) begin
                        req_d = 1'b0;
                        if (data_rdy) begin
                            done    = 1'b1;
                            ptr_d   = grant_nxt;
                            state_d = StIdle;
                        end else begin
                            state_d = StWait;
                        end
                    end else if (expired) begin
                        req_d   = 1'b0;
                        tmo_set = 1'b1;
                        ptr_d   = grant_nxt;
                        state_d = StIdle;
                    end
                end
                StWait: begin
                    if (data_rdy) begin
                        done    = 1'b1;
                        ptr_d   = grant_nxt;
                        state_d = StIdle;
                    end else if (expired) begin
                        tmo_set = 1'b1;
                        ptr_d   = grant_nxt;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // ok drops when the request falls or the address moves away from last cycle's value
    always_comb begin
        ok_d = '0;
        for (int i = 0; i < SLOTS; i++) begin
            ok_d[i] = slot_ok[i] & slot_req[i]
                    & (slot_addr[i*AW +: AW] == addr_q[i*AW +: AW]);
        end
        if (hit) ok_d[grant_q] = 1'b1;
        if (loop_rst) ok_d = '0;
    end

`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    assign expired = (cnt_q == 8'd254);

    // Restarts on every state change so REQ and WAIT each get their own budget
    always_comb begin
        cnt_d = '0;
        if (!loop_rst && state_q != StIdle && state_d == state_q) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign expired = 1'b0;
`endif

    assign timeout_err = tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            refresh_en <= 1'b1;
            slot_ok    <= '0;
            slot_dout  <= '0;
            addr_q     <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            sdram_req  <= req_d;
            sdram_addr <= addr_d;
            refresh_en <= ref_d;
            slot_ok    <= ok_d;
            addr_q     <= slot_addr;
            tmo_q      <= tmo_q | tmo_set;
            if (hit) slot_dout[grant_q*32 +: 32] <= data_read;
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: vector table, scoreboard and corner-case sequences.
// Define JTFRAME_SDRAM_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_jtframe_sdram_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                loop_rst = 1'b0;
    logic [SLOTS-1:0]    slot_req = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack = 1'b0;
    logic                data_rdy = 1'b0;
    logic [31:0]         data_read = '0;
    logic                refresh_en;
    logic                timeout_err;

    int checks = 0;
    int failures = 0;

    jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .loop_rst    (loop_rst),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          slot;
        logic [21:0] addr;
        int          ack_dly;
        int          rdy_dly;
        logic [31:0] data;
    } vec_t;

    exp_t             sb[$];
    exp_t             sb_e;
    logic [SLOTS-1:0] ok_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        return {10'h3C5, a} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [AW-1:0] rr_addr(input int k);
        return AW'(22'h100000 + k * 22'h1111);
    endfunction

    task automatic set_addr(input int s, input logic [AW-1:0] a);
        slot_addr[s*AW +: AW] = a;
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 1'b0;
        checks++;
        for (int n = 0; n < 40; n++) begin
            if (sdram_req) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            failures++;
            $display("FAIL %s: sdram_req still 0 after 40 cycles, expected 1", name);
        end
    endtask

    // Acts as the SDRAM controller for one transaction already requested
    task automatic serve(input int slot, input int ack_dly, input int rdy_dly,
                         input logic [31:0] data, input bit exp_hit);
        repeat (ack_dly) tick();
        sdram_ack = 1'b1;
        if (rdy_dly == 0) begin
            data_rdy  = 1'b1;
            data_read = data;
            if (exp_hit) sb.push_back('{slot: slot, data: data});
        end
        tick();
        sdram_ack = 1'b0;
        check("req_fall", sdram_req, 1'b0);
        if (rdy_dly != 0) begin
            repeat (rdy_dly - 1) tick();
            data_rdy  = 1'b1;
            data_read = data;
            if (exp_hit) sb.push_back('{slot: slot, data: data});
            tick();
        end
        data_rdy  = 1'b0;
        data_read = '0;
        check("ok_set", slot_ok[slot], exp_hit);
        if (exp_hit) check("dout", slot_dout[slot*32 +: 32], data);
    endtask

    // Scoreboard side: every rising ok must match the oldest expected delivery
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_ok[i] && !ok_prev[i]) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: slot_ok[%0d] rose, expected no delivery", i);
                end else begin
                    sb_e = sb.pop_front();
                    check("sb_slot", i, sb_e.slot);
                    check("sb_data", slot_dout[i*32 +: 32], sb_e.data);
                end
            end
        end
        ok_prev = slot_ok;
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{slot: 0, addr: 22'h001234, ack_dly: 2, rdy_dly: 5, data: 32'hDEAD_BEEF};
        vecs[1] = '{slot: 1, addr: 22'h3FFFFF, ack_dly: 0, rdy_dly: 1, data: 32'h0000_0001};
        vecs[2] = '{slot: 2, addr: 22'h000000, ack_dly: 1, rdy_dly: 0, data: 32'hFFFF_FFFF};
        vecs[3] = '{slot: 3, addr: 22'h2AAAAA, ack_dly: 3, rdy_dly: 2, data: 32'h1234_5678};
        vecs[4] = '{slot: 2, addr: 22'h155555, ack_dly: 0, rdy_dly: 0, data: 32'hA5A5_A5A5};
        vecs[5] = '{slot: 1, addr: 22'h000ABC, ack_dly: 4, rdy_dly: 3, data: 32'h0BAD_F00D};

        repeat (3) tick();
        check("rst_sdram_req", sdram_req, 1'b0);
        check("rst_sdram_addr", sdram_addr, '0);
        check("rst_slot_ok", slot_ok, '0);
        check("rst_slot_dout", slot_dout, '0);
        check("rst_refresh_en", refresh_en, 1'b1);
        check("rst_timeout_err", timeout_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single-slot transactions from the vector table
        for (int v = 0; v < 6; v++) begin
            set_addr(vecs[v].slot, vecs[v].addr);
            slot_req[vecs[v].slot] = 1'b1;
            tick();
            check("req_latency", sdram_req, 1'b1);
            check("req_addr", sdram_addr, vecs[v].addr);
            check("refresh_low", refresh_en, 1'b0);
            serve(vecs[v].slot, vecs[v].ack_dly, vecs[v].rdy_dly, vecs[v].data, 1'b1);
            check("refresh_busy", refresh_en, 1'b0);
            slot_req[vecs[v].slot] = 1'b0;
            tick();
            check("ok_clear", slot_ok[vecs[v].slot], 1'b0);
            check("dout_hold", slot_dout[vecs[v].slot*32 +: 32], vecs[v].data);
            check("refresh_idle", refresh_en, 1'b1);
        end

        // Round-robin: grant order 0,1,2,3 then slot 0's new address after slot 3
        loop_rst = 1'b1;
        tick();
        loop_rst = 1'b0;
        for (int s = 0; s < SLOTS; s++) set_addr(s, rr_addr(s));
        slot_req = '1;
        tick();
        for (int k = 0; k < SLOTS; k++) begin
            wait_req("rr_wait");
            check("rr_addr", sdram_addr, rr_addr(k));
            serve(k, 1, 2, mem(rr_addr(k)), 1'b1);
            if (k == 0) begin
                set_addr(0, 22'h0ABCDE);
                tick();
                check("rr_ok0_clear", slot_ok[0], 1'b0);
                check("rr_dout0_hold", slot_dout[31:0], mem(rr_addr(0)));
            end
        end
        wait_req("rr_wait0");
        check("rr_addr0_again", sdram_addr, 22'h0ABCDE);
        serve(0, 0, 1, mem(22'h0ABCDE), 1'b1);
        slot_req = '0;
        tick();

        // Address change during WAIT: data discarded, new address fetched back-to-back
        set_addr(1, 22'h0C0FFE);
        slot_req[1] = 1'b1;
        wait_req("mf_wait");
        check("mf_addr", sdram_addr, 22'h0C0FFE);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_addr(1, 22'h0BEEF0);
        tick();
        data_rdy  = 1'b1;
        data_read = mem(22'h0C0FFE);
        tick();
        data_rdy  = 1'b0;
        check("mf_ok_discard", slot_ok[1], 1'b0);
        check("mf_dout_keep", slot_dout[63:32], mem(rr_addr(1)));
        check("mf_req_gap", sdram_req, 1'b0);
        tick();
        check("mf_req_b2b", sdram_req, 1'b1);
        check("mf_addr_new", sdram_addr, 22'h0BEEF0);
        serve(1, 1, 1, mem(22'h0BEEF0), 1'b1);
        slot_req[1] = 1'b0;
        tick();

        // loop_rst during WAIT
        set_addr(3, 22'h033333);
        slot_req[3] = 1'b1;
        wait_req("lr_wait3");
        serve(3, 0, 1, mem(22'h033333), 1'b1);
        set_addr(2, 22'h022222);
        slot_req[2] = 1'b1;
        wait_req("lr_wait2");
        check("lr_addr2", sdram_addr, 22'h022222);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_addr(0, 22'h011111);
        slot_req[0] = 1'b1;
        loop_rst = 1'b1;
        tick();
        check("lr_req", sdram_req, 1'b0);
        check("lr_ok", slot_ok, '0);
        check("lr_refresh", refresh_en, 1'b1);
        data_rdy  = 1'b1;
        data_read = 32'hBAD0_BAD0;
        tick();
        data_rdy = 1'b0;
        check("lr_rdy_ignored", slot_ok, '0);
        tick();
        check("lr_no_grant", sdram_req, 1'b0);
        check("lr_dout3_keep", slot_dout[127:96], mem(22'h033333));
        loop_rst = 1'b0;
        tick();
        check("lr_first_req", sdram_req, 1'b1);
        check("lr_first_slot0", sdram_addr, 22'h011111);
        serve(0, 1, 1, mem(22'h011111), 1'b1);
        wait_req("lr_wait_next");
        check("lr_next_slot2", sdram_addr, 22'h022222);
        serve(2, 0, 2, mem(22'h022222), 1'b1);
        wait_req("lr_wait_last");
        check("lr_last_slot3", sdram_addr, 22'h033333);
        serve(3, 2, 1, mem(22'h033333), 1'b1);
        slot_req = '0;
        tick();
        check("end_refresh_idle", refresh_en, 1'b1);

`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
        begin
            int n;
            set_addr(0, 22'h02F00D);
            slot_req[0] = 1'b1;
            wait_req("tmo_wait");
            n = 0;
            while (sdram_req && n < 400) begin
                n++;
                tick();
            end
            check("tmo_req_cycles", n, 255);
            check("tmo_err", timeout_err, 1'b1);
            tick();
            check("tmo_retry", sdram_req, 1'b1);
            check("tmo_retry_addr", sdram_addr, 22'h02F00D);
            serve(0, 1, 1, mem(22'h02F00D), 1'b1);
            slot_req = '0;
            tick();
            check("tmo_err_sticky", timeout_err, 1'b1);
        end
`else
        check("tmo_err_tied", timeout_err, 1'b0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
